// File: rtl/rvcpu_pkg.sv
// Shared writeback types and default widths for the CPU register-file path.
package rvcpu_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_req_t;

   typedef enum logic [1:0] {
      WB_ALU,
      WB_LD,
      WB_MD
   } wb_src_e;

endpackage

// File: rtl/rvcpu_scoreboard.sv
// Pending-destination scoreboard: tracks registers awaiting a long-latency
// writeback and flags protocol violations against that state.
module rvcpu_scoreboard #(
   parameter int unsigned REG_AW = 5
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     set_en_i,
   input  logic [REG_AW-1:0]        set_rd_i,
   input  logic                     clr_en_i,
   input  logic [REG_AW-1:0]        clr_rd_i,
   input  logic                     alu_en_i,
   input  logic [REG_AW-1:0]        alu_rd_i,
   output logic [(1<<REG_AW)-1:0]   busy_o,
   output logic                     sb_err_o
);

   localparam int unsigned NREG = 1 << REG_AW;

   logic [NREG-1:0] busy_q, busy_d;
   logic            err_q, err_d;
   logic            clr_hit, set_hit;

   // Next busy vector (set beats clear so a register can be reissued on the
   // cycle its previous result drains) and sticky error detection.
   always_comb begin
      busy_d  = busy_q;
      clr_hit = clr_en_i && (clr_rd_i != '0);
      set_hit = set_en_i && (set_rd_i != '0);
      if (clr_hit) busy_d[clr_rd_i] = 1'b0;
      if (set_hit) busy_d[set_rd_i] = 1'b1;
      busy_d[0] = 1'b0;

      err_d = err_q;
      if (set_hit && busy_q[set_rd_i] && !(clr_hit && (clr_rd_i == set_rd_i)))
         err_d = 1'b1;
      if (clr_hit && !busy_q[clr_rd_i])
         err_d = 1'b1;
      if (alu_en_i && (alu_rd_i != '0) && busy_q[alu_rd_i])
         err_d = 1'b1;
   end

   // Scoreboard state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         err_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         err_q  <= err_d;
      end
   end

   assign busy_o   = busy_q;
   assign sb_err_o = err_q;

endmodule

// File: rtl/rvcpu_wb_arbiter.sv
// Writeback arbiter: merges ALU, load and mul/div results onto the register
// file write port with a one-cycle registered output and round-robin between
// the two long-latency sources.
module rvcpu_wb_arbiter
   import rvcpu_pkg::*;
#(
   parameter int unsigned XLEN   = rvcpu_pkg::XLEN,
   parameter int unsigned REG_AW = rvcpu_pkg::REG_AW
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    alu_valid,
   input  logic [REG_AW-1:0]       alu_rd,
   input  logic [XLEN-1:0]         alu_data,
   input  logic                    ld_valid,
   output logic                    ld_ready,
   input  logic [REG_AW-1:0]       ld_rd,
   input  logic [XLEN-1:0]         ld_data,
   input  logic                    md_valid,
   output logic                    md_ready,
   input  logic [REG_AW-1:0]       md_rd,
   input  logic [XLEN-1:0]         md_data,
   input  logic                    issue_en,
   input  logic [REG_AW-1:0]       issue_rd,
   output logic                    w_en,
   output logic [REG_AW-1:0]       w_addr,
   output logic [XLEN-1:0]         w_data,
   output logic [(1<<REG_AW)-1:0]  busy,
   output logic                    sb_err
);

   logic              rr_q, rr_d;
   logic              w_en_q;
   logic [REG_AW-1:0] w_addr_q;
   logic [XLEN-1:0]   w_data_q;

   logic              ld_hs, md_hs;
   logic              gnt_valid;
   wb_src_e           gnt_src;
   logic [REG_AW-1:0] gnt_rd;
   logic [XLEN-1:0]   gnt_data;
   logic [REG_AW-1:0] clr_rd;

   // Grant selection: ALU always wins; otherwise rr picks between load and
   // mul/div. Each ready looks only at the competing source's valid.
   always_comb begin
      ld_ready  = !alu_valid && (!md_valid || !rr_q);
      md_ready  = !alu_valid && (!ld_valid ||  rr_q);
      ld_hs     = ld_valid && ld_ready;
      md_hs     = md_valid && md_ready;
      gnt_valid = alu_valid || ld_hs || md_hs;

      gnt_src = WB_ALU;
      if (ld_hs)      gnt_src = WB_LD;
      else if (md_hs) gnt_src = WB_MD;

      case (gnt_src)
         WB_LD: begin
            gnt_rd   = ld_rd;
            gnt_data = ld_data;
         end
         WB_MD: begin
            gnt_rd   = md_rd;
            gnt_data = md_data;
         end
         default: begin
            gnt_rd   = alu_rd;
            gnt_data = alu_data;
         end
      endcase

      rr_d = rr_q;
      if (ld_hs)      rr_d = 1'b1;
      else if (md_hs) rr_d = 1'b0;

      clr_rd = ld_hs ? ld_rd : md_rd;
   end

   // Round-robin pointer and registered write port.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q     <= 1'b0;
         w_en_q   <= 1'b0;
         w_addr_q <= '0;
         w_data_q <= '0;
      end else begin
         rr_q <= rr_d;
         if (gnt_valid) begin
            w_en_q   <= (gnt_rd != '0);
            w_addr_q <= gnt_rd;
            w_data_q <= gnt_data;
         end else begin
            w_en_q   <= 1'b0;
         end
      end
   end

   assign w_en   = w_en_q;
   assign w_addr = w_addr_q;
   assign w_data = w_data_q;

   rvcpu_scoreboard #(
      .REG_AW (REG_AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en_i (issue_en),
      .set_rd_i (issue_rd),
      .clr_en_i (ld_hs || md_hs),
      .clr_rd_i (clr_rd),
      .alu_en_i (alu_valid),
      .alu_rd_i (alu_rd),
      .busy_o   (busy),
      .sb_err_o (sb_err)
   );

endmodule

// File: tb/tb_rvcpu_wb_arbiter.sv
// Self-checking bench for the writeback arbiter: directed scenarios plus a
// randomized legal-traffic run against a queue-based reference model.
module tb_rvcpu_wb_arbiter;
   import rvcpu_pkg::*;

   localparam int XW = 32;
   localparam int AW = 5;
   localparam int NR = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          alu_valid, ld_valid, md_valid, issue_en;
   logic [AW-1:0] alu_rd, ld_rd, md_rd, issue_rd;
   logic [XW-1:0] alu_data, ld_data, md_data;
   logic          ld_ready, md_ready, w_en, sb_err;
   logic [AW-1:0] w_addr;
   logic [XW-1:0] w_data;
   logic [NR-1:0] busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rvcpu_wb_arbiter #(.XLEN(XW), .REG_AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
      .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
      .issue_en(issue_en), .issue_rd(issue_rd),
      .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
      .busy(busy), .sb_err(sb_err)
   );

   task automatic idle_inputs();
      alu_valid = 0; alu_rd = '0; alu_data = '0;
      ld_valid  = 0; ld_rd  = '0; ld_data  = '0;
      md_valid  = 0; md_rd  = '0; md_data  = '0;
      issue_en  = 0; issue_rd = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      tick();
   endtask

   task automatic test_reset();
      idle_inputs();
      tick();
      rst_n = 0;
      #1;
      checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL reset_w_en: got %b expected 0", w_en); end
      checks++; if (w_addr !== '0) begin errors++; $display("FAIL reset_w_addr: got %h expected 0", w_addr); end
      checks++; if (w_data !== '0) begin errors++; $display("FAIL reset_w_data: got %h expected 0", w_data); end
      checks++; if (busy !== '0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy); end
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL reset_sb_err: got %b expected 0", sb_err); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      tick();
      checks++; if (ld_ready !== 1'b1 || md_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got ld=%b md=%b expected 1/1", ld_ready, md_ready); end
      checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL reset_idle_w_en: got %b expected 0", w_en); end
   endtask

   task automatic test_alu_write();
      idle_inputs();
      alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      tick();
      idle_inputs();
      checks++; if (w_en !== 1'b1 || w_addr !== 5'd5 || w_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_write: got en=%b addr=%0d data=%h expected 1/5/deadbeef", w_en, w_addr, w_data); end
      tick();
      checks++; if (w_en !== 1'b0) begin errors++; $display("FAIL alu_write_drop: got %b expected 0", w_en); end
      checks++; if (busy !== '0) begin errors++; $display("FAIL alu_busy: got %h expected 0", busy); end
   endtask

   task automatic test_ld_blocked_by_alu();
      idle_inputs();
      issue_en = 1; issue_rd = 7;
      tick();
      idle_inputs();
      checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL ld_issue_busy: got %h expected 00000080", busy); end
      ld_valid = 1; ld_rd = 7; ld_data = 32'h1234;
      alu_valid = 1; alu_rd = 8; alu_data = 32'hA5A5_0001;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL ld_blocked_%0d: got ld_ready=%b expected 0", i, ld_ready); end
         tick();
         checks++; if (busy[7] !== 1'b1) begin errors++; $display("FAIL ld_blocked_busy_%0d: got %b expected 1", i, busy[7]); end
      end
      alu_valid = 0;
      #1;
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL ld_unblocked: got ld_ready=%b expected 1", ld_ready); end
      tick();
      idle_inputs();
      checks++; if (busy !== '0) begin errors++; $display("FAIL ld_clear_busy: got %h expected 0", busy); end
      checks++; if (w_en !== 1'b1 || w_addr !== 5'd7 || w_data !== 32'h1234) begin errors++; $display("FAIL ld_write: got en=%b addr=%0d data=%h expected 1/7/00001234", w_en, w_addr, w_data); end
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL ld_sb_err: got %b expected 0", sb_err); end
   endtask

   task automatic test_rr_order();
      do_reset();
      issue_en = 1; issue_rd = 3;
      tick();
      issue_rd = 4;
      tick();
      idle_inputs();
      ld_valid = 1; ld_rd = 3; ld_data = 32'h3333_0003;
      md_valid = 1; md_rd = 4; md_data = 32'h4444_0004;
      #1;
      checks++; if (ld_ready !== 1'b1 || md_ready !== 1'b0) begin errors++; $display("FAIL rr_first: got ld=%b md=%b expected 1/0", ld_ready, md_ready); end
      tick();
      ld_valid = 0;
      checks++; if (w_en !== 1'b1 || w_addr !== 5'd3 || w_data !== 32'h3333_0003) begin errors++; $display("FAIL rr_write1: got en=%b addr=%0d data=%h expected 1/3/33330003", w_en, w_addr, w_data); end
      #1;
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL rr_second: got md_ready=%b expected 1", md_ready); end
      tick();
      idle_inputs();
      checks++; if (w_en !== 1'b1 || w_addr !== 5'd4 || w_data !== 32'h4444_0004) begin errors++; $display("FAIL rr_write2: got en=%b addr=%0d data=%h expected 1/4/44440004", w_en, w_addr, w_data); end
      checks++; if (busy !== '0) begin errors++; $display("FAIL rr_busy: got %h expected 0", busy); end
      // Offer both again without letting an edge pass: load must be preferred.
      ld_valid = 1; md_valid = 1;
      #1;
      checks++; if (ld_ready !== 1'b1 || md_ready !== 1'b0) begin errors++; $display("FAIL rr_end: got ld=%b md=%b expected 1/0", ld_ready, md_ready); end
      idle_inputs();
   endtask

   task automatic test_rd_zero();
      idle_inputs();
      ld_valid = 1; ld_rd = 0; ld_data = 32'hFFFF_0000;
      #1;
      checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready: got %b expected 1", ld_ready); end
      tick();
      idle_inputs();
      checks++; if (w_en !== 1'b0 || w_addr !== 5'd0) begin errors++; $display("FAIL rd0_write: got en=%b addr=%0d expected 0/0", w_en, w_addr); end
      checks++; if (busy !== '0 || sb_err !== 1'b0) begin errors++; $display("FAIL rd0_state: got busy=%h err=%b expected 0/0", busy, sb_err); end
   endtask

   task automatic test_set_clear_same();
      idle_inputs();
      issue_en = 1; issue_rd = 9;
      tick();
      md_valid = 1; md_rd = 9; md_data = 32'h9999_9999;
      #1;
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL same_md_ready: got %b expected 1", md_ready); end
      tick();
      idle_inputs();
      checks++; if (busy !== 32'h0000_0200 || sb_err !== 1'b0) begin errors++; $display("FAIL same_busy: got busy=%h err=%b expected 00000200/0", busy, sb_err); end
      checks++; if (w_en !== 1'b1 || w_addr !== 5'd9) begin errors++; $display("FAIL same_write: got en=%b addr=%0d expected 1/9", w_en, w_addr); end
      md_valid = 1; md_rd = 9; md_data = 32'h1;
      tick();
      idle_inputs();
      checks++; if (busy !== '0 || sb_err !== 1'b0) begin errors++; $display("FAIL same_drain: got busy=%h err=%b expected 0/0", busy, sb_err); end
   endtask

   task automatic test_err_and_async_reset();
      idle_inputs();
      issue_en = 1; issue_rd = 2;
      tick();
      checks++; if (sb_err !== 1'b0) begin errors++; $display("FAIL err_first_issue: got %b expected 0", sb_err); end
      tick();
      idle_inputs();
      checks++; if (sb_err !== 1'b1) begin errors++; $display("FAIL err_double_issue: got %b expected 1", sb_err); end
      alu_valid = 1; alu_rd = 6; alu_data = 32'h6666_6666;
      tick();
      idle_inputs();
      checks++; if (sb_err !== 1'b1 || w_en !== 1'b1 || busy !== 32'h0000_0004) begin errors++; $display("FAIL err_sticky: got err=%b en=%b busy=%h expected 1/1/00000004", sb_err, w_en, busy); end
      #2;
      rst_n = 0;
      #1;
      checks++; if (w_en !== 1'b0 || w_addr !== '0 || w_data !== '0 || busy !== '0 || sb_err !== 1'b0) begin
         errors++; $display("FAIL async_reset: got en=%b addr=%h data=%h busy=%h err=%b expected all 0", w_en, w_addr, w_data, busy, sb_err);
      end
      @(negedge clk);
      rst_n = 1;
   endtask

   // Random legal traffic. The model thinks in terms of outstanding results
   // per unit and which unit's turn it is, then predicts the write port.
   task automatic test_random();
      wb_req_t       ldq[$];
      wb_req_t       mdq[$];
      bit            pend[NR];
      bit            turn_md = 0;
      bit            err_m = 0;
      bit            ld_up = 0, md_up = 0;
      logic          exp_wen = 0;
      logic [AW-1:0] exp_waddr = '0;
      logic [XW-1:0] exp_wdata = '0;
      logic [NR-1:0] exp_busy;
      do_reset();
      for (int i = 0; i < NR; i++) pend[i] = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         bit            exp_ldr, exp_mdr, ld_hs, md_hs, do_iss, granted;
         logic [AW-1:0] r, nrd, crd;
         logic [XW-1:0] ndata;
         wb_req_t       e;

         if (!ld_up && ldq.size() > 0 && $urandom_range(0, 1) == 1) ld_up = 1;
         if (!md_up && mdq.size() > 0 && $urandom_range(0, 1) == 1) md_up = 1;
         ld_valid = ld_up;
         md_valid = md_up;
         if (ld_up) begin ld_rd = ldq[0].rd; ld_data = ldq[0].data; end
         else begin ld_rd = AW'($urandom); ld_data = $urandom; end
         if (md_up) begin md_rd = mdq[0].rd; md_data = mdq[0].data; end
         else begin md_rd = AW'($urandom); md_data = $urandom; end

         alu_valid = ($urandom_range(0, 2) == 0);
         r = AW'($urandom);
         if (pend[r]) r = '0;
         alu_rd = r; alu_data = $urandom;

         do_iss = ($urandom_range(0, 2) == 0);
         r = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, NR-1));
         if (pend[r]) do_iss = 0;
         issue_en = do_iss; issue_rd = r;
         #2;

         // A unit is ready whenever it would win were it offering a result.
         exp_ldr = !alu_valid && !(md_up && turn_md);
         exp_mdr = !alu_valid && !(ld_up && !turn_md);
         checks++; if (ld_ready !== exp_ldr || md_ready !== exp_mdr) begin
            errors++; $display("FAIL rand_ready c%0d: got ld=%b md=%b expected %b/%b", cyc, ld_ready, md_ready, exp_ldr, exp_mdr);
         end
         ld_hs = ld_up && exp_ldr;
         md_hs = md_up && exp_mdr;

         granted = 1; nrd = '0; ndata = '0;
         if (alu_valid)  begin nrd = alu_rd; ndata = alu_data; end
         else if (ld_hs) begin nrd = ldq[0].rd; ndata = ldq[0].data; end
         else if (md_hs) begin nrd = mdq[0].rd; ndata = mdq[0].data; end
         else granted = 0;
         if (granted) begin exp_wen = (nrd != 0); exp_waddr = nrd; exp_wdata = ndata; end
         else exp_wen = 0;

         if (alu_valid && alu_rd != 0 && pend[alu_rd]) err_m = 1;
         crd = ld_hs ? ldq[0].rd : (md_hs ? mdq[0].rd : AW'(0));
         if ((ld_hs || md_hs) && crd != 0 && !pend[crd]) err_m = 1;
         if (do_iss && r != 0 && pend[r] && !((ld_hs || md_hs) && crd == r)) err_m = 1;
         if ((ld_hs || md_hs) && crd != 0) pend[crd] = 0;
         if (do_iss && r != 0) pend[r] = 1;
         if (ld_hs) turn_md = 1;
         else if (md_hs) turn_md = 0;

         tick();
         for (int i = 0; i < NR; i++) exp_busy[i] = pend[i];
         checks++; if (w_en !== exp_wen || w_addr !== exp_waddr || w_data !== exp_wdata) begin
            errors++; $display("FAIL rand_write c%0d: got en=%b addr=%0d data=%h expected %b/%0d/%h", cyc, w_en, w_addr, w_data, exp_wen, exp_waddr, exp_wdata);
         end
         checks++; if (busy !== exp_busy || sb_err !== err_m) begin
            errors++; $display("FAIL rand_sb c%0d: got busy=%h err=%b expected %h/%b", cyc, busy, sb_err, exp_busy, err_m);
         end

         if (ld_hs) begin void'(ldq.pop_front()); ld_up = 0; end
         if (md_hs) begin void'(mdq.pop_front()); md_up = 0; end
         if (do_iss) begin
            e.valid = 1; e.rd = r; e.data = $urandom;
            if ($urandom_range(0, 1) == 1) ldq.push_back(e);
            else mdq.push_back(e);
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_alu_write();
      test_ld_blocked_by_alu();
      test_rr_order();
      test_rd_zero();
      test_set_clear_same();
      test_err_and_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
